// File: rtl/cache_ctrl_pkg.sv
// Shared types for the unified-cache sequencer: FSM state encoding and port ids.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MEM    = 2'd2,
        FILL   = 2'd3
    } state_t;

    localparam logic PORT_IF   = 1'b0;  // instruction fetch
    localparam logic PORT_DATA = 1'b1;  // data load/store

    // One-hot completion vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DATA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that was not granted last wins.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: en gates the grant; no grant is issued while en is low.
// Ports: req[1:0] requests, last_grant previous winner, en arbitration enable,
//        grant winning index, grant_vld a grant is being issued this cycle.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant,
    output logic       grant_vld
);

    always_comb begin
        grant_vld = en & (|req);
        // Sole requester wins outright; on a tie alternate away from last_grant.
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Sequences one shared unified cache between fetch (port 0) and load/store (port 1), write-through.
// Latency: read hit ready 1 cycle after the IDLE sample; miss/write ready 1 cycle after mem_ack.
// Backpressure: one request at a time; req is held until ready; mem_req held until mem_ack or timeout.
// Ports: clk/rst; req/we/addr0/addr1/wdata0/wdata1 requester side; ready/rdata/err completion;
//        cache_* strobes, latched address/data, fill word and probe hit; mem_* backing-memory handshake.
module cache_mem_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [29:0] addr0,
    input  logic [29:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [29:0] cache_addr,
    output logic        cache_read_en,
    output logic        cache_write_en,
    output logic [31:0] cache_wdata,
    output logic [31:0] cache_fill_data,
    input  logic [31:0] cache_rdata,
    input  logic        cache_probe_hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_t            state;
    logic              last_grant;
    logic              port_q;
    logic              we_q;
    logic              tmo_q;       // FILL reached by timeout rather than by mem_ack
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_nxt;

    logic              grant;
    logic              grant_vld;

    logic              hit_done;
    logic              fill_ok;
    logic              rd_strobe;

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant      (grant),
        .grant_vld  (grant_vld)
    );

    assign tmo_cnt_nxt = tmo_cnt + TMO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= PORT_DATA;
            port_q          <= PORT_IF;
            we_q            <= 1'b0;
            tmo_q           <= 1'b0;
            tmo_cnt         <= '0;
            cache_addr      <= '0;
            cache_wdata     <= '0;
            cache_fill_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        port_q      <= grant;
                        last_grant  <= grant;
                        we_q        <= we[grant];
                        cache_addr  <= grant ? addr1 : addr0;
                        cache_wdata <= grant ? wdata1 : wdata0;
                        tmo_q       <= 1'b0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q && cache_probe_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= '0;
                        state   <= MEM;
                    end
                end
                MEM: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        if (!we_q) begin
                            cache_fill_data <= mem_rdata;
                        end
                        state <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt_nxt;
                        if (tmo_cnt_nxt == TMO_LIMIT) begin
                            tmo_q <= 1'b1;
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion outputs decode the registered state; the hit path must use the
    // combinational probe because the cache only sees the address in ACCESS.
    always_comb begin
        hit_done       = (state == ACCESS) && !we_q && cache_probe_hit;
        fill_ok        = (state == FILL) && !tmo_q;
        rd_strobe      = hit_done || (fill_ok && !we_q);

        cache_read_en  = rd_strobe;
        cache_write_en = fill_ok && we_q;
        ready          = (hit_done || (state == FILL)) ? port_onehot(port_q) : 2'b00;
        rdata          = rd_strobe ? cache_rdata : 32'h0;
        err            = (state == FILL) && tmo_q;

        mem_req        = (state == MEM);
        mem_we         = (state == MEM) && we_q;
        mem_addr       = cache_addr;
        mem_wdata      = cache_wdata;
    end

endmodule
